// File: rtl/pic_loader.sv
// pic_loader: streams a PIC program image (2 bytes per 14-bit word) over a simple
//   strobe/ready bus into a target held in reset, optionally reads each word back,
//   then releases the target. One bus cycle at a time, with an idle cycle between cycles.
// Backpressure: byte_ready only in RX_LO/RX_HI; the bus waits for ready up to TIMEOUT cycles.
// Ports: clk/reset (sync, active-high); start; byte_in/byte_valid/byte_ready image stream;
//   address/wdata/rdata/wen/ren/ready bus; busy/done/error/word_count status.
module pic_loader #(
  parameter int          NWORDS    = 1024,
  parameter logic [15:0] PROG_BASE = 16'h8000,
  parameter logic [15:0] CTL_ADDR  = 16'h0000,
  parameter int          VERIFY    = 1,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] address,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        wen,
  output logic        ren,
  input  logic        ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] word_count
);

  typedef enum logic [3:0] {
    IDLE, HOLD, RX_LO, RX_HI, WRITE, READ, RELEASE, FIN, ERR
  } state_t;

  localparam logic [10:0] LAST_WORD = 11'(NWORDS);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        on, on_nxt;      // bus strobe currently asserted
  logic [7:0]  tcnt;            // cycles the current strobe has been high, minus one
  logic [7:0]  lo_byte;
  logic [13:0] word;
  logic        err_q;
  logic [10:0] count;
  logic [10:0] count_inc;
  logic [15:0] prog_addr;
  logic        xfer, bus_state, bus_done, bus_tmo, inc;

  // Only the low 14 bits of the readback are meaningful to the target.
  logic unused_rdata;
  assign unused_rdata = ^rdata[31:14];

  assign byte_ready = (state == RX_LO) || (state == RX_HI);
  assign xfer       = byte_valid && byte_ready;
  assign count_inc  = count + 11'd1;
  assign prog_addr  = PROG_BASE + {3'b000, count, 2'b00};
  assign bus_state  = (state == HOLD) || (state == WRITE) || (state == READ) || (state == RELEASE);
  // ready is only meaningful while a strobe is up.
  assign bus_done   = on && ready;
  assign bus_tmo    = on && !ready && (tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      on    <= 1'b0;
    end else begin
      state <= state_nxt;
      on    <= on_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    on_nxt    = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = HOLD;
      HOLD:    if (bus_done) state_nxt = RX_LO;
      RX_LO:   if (xfer) state_nxt = RX_HI;
      RX_HI:   if (xfer) state_nxt = (byte_in[7:6] != 2'b00) ? ERR : WRITE;
      WRITE: begin
        if (bus_done) begin
          if (VERIFY != 0) begin
            state_nxt = READ;
          end else begin
            inc       = 1'b1;
            state_nxt = (count_inc == LAST_WORD) ? RELEASE : RX_LO;
          end
        end
      end
      READ: begin
        if (bus_done) begin
          if (rdata[13:0] != word) begin
            state_nxt = ERR;
          end else begin
            inc       = 1'b1;
            state_nxt = (count_inc == LAST_WORD) ? RELEASE : RX_LO;
          end
        end
      end
      RELEASE: if (bus_done) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus_tmo) state_nxt = ERR;
    // The first cycle in every bus state is left idle; this gives the
    // mandatory gap between back-to-back bus cycles.
    if (bus_state) on_nxt = on ? !(bus_done || bus_tmo) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= 8'd0;
      lo_byte <= 8'd0;
      word    <= 14'd0;
      err_q   <= 1'b0;
      count   <= 11'd0;
    end else begin
      if (!on) tcnt <= 8'd0;
      else     tcnt <= tcnt + 8'd1;
      if (state == IDLE && start) begin
        err_q <= 1'b0;
        count <= 11'd0;
      end
      if (state_nxt == ERR) err_q <= 1'b1;
      if (state == RX_LO && xfer) lo_byte <= byte_in;
      if (state == RX_HI && xfer) word <= {byte_in[5:0], lo_byte};
      if (inc) count <= count_inc;
    end
  end

  assign wen = on && ((state == HOLD) || (state == WRITE) || (state == RELEASE));
  assign ren = on && (state == READ);

  always_comb begin
    address = 16'h0000;
    wdata   = 32'h0;
    if (on) begin
      if (state == WRITE || state == READ) address = prog_addr;
      else                                 address = CTL_ADDR;
    end
    if (wen) begin
      if (state == HOLD)       wdata = 32'h1;
      else if (state == WRITE) wdata = {18'b0, word};
    end
  end

  assign busy       = (state != IDLE) && (state != FIN) && (state != ERR);
  assign done       = (state == FIN);
  assign error      = err_q;
  assign word_count = count;

endmodule

// File: tb/tb_pic_loader.sv
// tb_pic_loader: scenario tests for pic_loader (NWORDS=2, TIMEOUT=4) against an echoing
//   bus slave; expected bus operations are queued per scenario and checked as they complete.
// Slave drives ready/rdata at the falling edge; stimulus changes 1 time unit after the rising edge.
module tb_pic_loader;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
  } op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wen, ren;
  logic        ready;
  logic        busy, done, error;
  logic [10:0] word_count;

  int errors = 0;
  int checks = 0;
  op_t exp_q[$];
  logic [7:0] feed_q[$];
  logic [31:0] mem [logic [15:0]];
  int delay_cfg = 0;
  bit never_ready = 0;
  bit spurious = 0;
  bit corrupt = 0;

  pic_loader #(
    .NWORDS(2), .PROG_BASE(16'h8000), .CTL_ADDR(16'h0000), .VERIFY(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .address(address), .wdata(wdata), .rdata(rdata),
    .wen(wen), .ren(ren), .ready(ready),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Echoing slave and bus scoreboard.
  initial begin
    int scnt;
    bit prev_on, prev_done;
    logic [15:0] h_addr;
    logic [31:0] h_wdata;
    logic h_wen;
    op_t e;
    scnt = 0; prev_on = 0; prev_done = 0;
    h_addr = 0; h_wdata = 0; h_wen = 0;
    ready = 1'b0; rdata = 32'h0;
    forever begin
      @(negedge clk);
      checks++;
      if (!wen && wdata !== 32'h0) begin
        errors++; $display("FAIL wdata_idle: got %h required 0", wdata);
      end
      if (wen || ren) begin
        checks++;
        if (wen && ren) begin errors++; $display("FAIL strobe_overlap: wen=1 ren=1 required exclusive"); end
        checks++;
        if (prev_done) begin errors++; $display("FAIL bus_gap: strobe high right after completion, required idle cycle"); end
        if (!prev_on) begin
          h_addr = address; h_wdata = wdata; h_wen = wen;
        end else begin
          checks++;
          if (address !== h_addr || wdata !== h_wdata || wen !== h_wen) begin
            errors++;
            $display("FAIL bus_stable: got addr=%h wdata=%h wen=%b required addr=%h wdata=%h wen=%b",
                     address, wdata, wen, h_addr, h_wdata, h_wen);
          end
        end
        scnt++;
        ready = !never_ready && (scnt > delay_cfg);
        rdata = 32'h0;
        if (ren) begin
          if (mem.exists(address)) rdata = mem[address];
          if (corrupt && address == 16'h8000) rdata = rdata + 32'd1;
        end
        if (ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: got w=%b addr=%h wdata=%h required no bus op", wen, address, wdata);
          end else begin
            e = exp_q.pop_front();
            if (e.w !== wen || e.a !== address || (e.w && e.d !== wdata)) begin
              errors++;
              $display("FAIL bus_op: got w=%b addr=%h wdata=%h required w=%b addr=%h wdata=%h",
                       wen, address, wdata, e.w, e.a, e.d);
            end
          end
          if (wen) mem[address] = wdata;
        end
        prev_done = ready;
      end else begin
        scnt = 0;
        ready = spurious;
        rdata = 32'h0;
        prev_done = 0;
      end
      prev_on = wen || ren;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic op_t mk(input logic w, input logic [15:0] a, input logic [31:0] d);
    op_t o;
    o.w = w; o.a = a; o.d = d;
    return o;
  endfunction

  function automatic void push_full_load();
    exp_q.push_back(mk(1'b1, 16'h0000, 32'h1));
    exp_q.push_back(mk(1'b1, 16'h8000, 32'h1234));
    exp_q.push_back(mk(1'b0, 16'h8000, 32'h0));
    exp_q.push_back(mk(1'b1, 16'h8004, 32'h3FFF));
    exp_q.push_back(mk(1'b0, 16'h8004, 32'h0));
    exp_q.push_back(mk(1'b1, 16'h0000, 32'h0));
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int gap);
    logic [7:0] b;
    bit got;
    while (feed_q.size() > 0) begin
      b = feed_q.pop_front();
      repeat (gap) begin @(posedge clk); #1; end
      byte_in = b; byte_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (byte_ready) got = 1;
        @(posedge clk); #1;
      end
      byte_valid = 1'b0; byte_in = 8'h00;
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL byte_accept: byte %h not taken within 200 cycles", b);
        feed_q.delete();
      end
    end
  endtask

  task automatic run_wait(input int limit, output int ndone, output bit err_seen, output bit timed_out);
    ndone = 0; err_seen = 0; timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (error) begin err_seen = 1; timed_out = 0; break; end
      if (ndone > 0 && !busy && !done) begin timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, wen, ren, busy, done, error} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 000000", {byte_ready, wen, ren, busy, done, error});
    end
    checks++;
    if (word_count !== 11'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", word_count); end
    checks++;
    if (address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h required 0000", address); end
    checks++;
    if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", wdata); end
  endtask

  task automatic test_basic_load();
    int nd; bit es, to;
    delay_cfg = 0; corrupt = 0; never_ready = 0; spurious = 0;
    push_full_load();
    feed_q = '{8'h34, 8'h12, 8'hFF, 8'h3F};
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL start_accept: got busy=%b error=%b required busy=1 error=0", busy, error);
    end
    fork
      feed(0);
      run_wait(400, nd, es, to);
    join
    checks++;
    if (nd !== 1 || to) begin errors++; $display("FAIL load_done: got %0d done pulses (timeout=%0b) required 1", nd, to); end
    checks++;
    if (es) begin errors++; $display("FAIL load_error: got error=1 required 0"); end
    repeat (3) @(negedge clk);
    checks++;
    if (word_count !== 11'd2) begin errors++; $display("FAIL load_count: got %0d required 2", word_count); end
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL load_idle: got busy=%b byte_ready=%b required 0 0", busy, byte_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL load_ops: %0d bus ops missing required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_verify_fail();
    int nd; bit es, to;
    delay_cfg = 0; corrupt = 1;
    exp_q.push_back(mk(1'b1, 16'h0000, 32'h1));
    exp_q.push_back(mk(1'b1, 16'h8000, 32'h1234));
    exp_q.push_back(mk(1'b0, 16'h8000, 32'h0));
    feed_q = '{8'h34, 8'h12};
    pulse_start();
    fork
      feed(0);
      run_wait(400, nd, es, to);
    join
    checks++;
    if (!es || error !== 1'b1) begin errors++; $display("FAIL verify_error: got error=%b required 1", error); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL verify_busy: got %b required 0", busy); end
    repeat (10) @(negedge clk);
    checks++;
    if (word_count !== 11'd0) begin errors++; $display("FAIL verify_count: got %0d required 0", word_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL verify_ops: %0d bus ops missing required 0", exp_q.size()); exp_q.delete(); end
    corrupt = 0;
  endtask

  task automatic test_bad_hi();
    exp_q.push_back(mk(1'b1, 16'h0000, 32'h1));
    feed_q = '{8'h34, 8'h40};
    pulse_start();
    feed(0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL badhi_err: got error=%b busy=%b required 1 0", error, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL badhi_ops: got %0d missing ops byte_ready=%b required 0 0", exp_q.size(), byte_ready);
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int nw;
    never_ready = 1;
    pulse_start();
    nw = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wen) nw++;
      if (error) break;
    end
    checks++;
    if (nw != 4) begin errors++; $display("FAIL timeout_wen: got %0d wen cycles required 4", nw); end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_err: got error=%b busy=%b required 1 0", error, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || wen !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: got error=%b wen=%b required 1 0", error, wen);
    end
    never_ready = 0;
  endtask

  task automatic test_gapped();
    int nd; bit es, to;
    delay_cfg = 3; spurious = 1;
    push_full_load();
    feed_q = '{8'h34, 8'h12, 8'hFF, 8'h3F};
    pulse_start();
    fork
      feed(10);
      run_wait(2000, nd, es, to);
      begin
        // A start pulse mid-run must be ignored.
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    checks++;
    if (nd !== 1 || es || to) begin
      errors++; $display("FAIL gapped_done: got done=%0d error=%0b timeout=%0b required 1 0 0", nd, es, to);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (word_count !== 11'd2) begin errors++; $display("FAIL gapped_count: got %0d required 2", word_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL gapped_ops: %0d bus ops missing required 0", exp_q.size()); exp_q.delete(); end
    delay_cfg = 0; spurious = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    delay_cfg = 3;
    exp_q.push_back(mk(1'b1, 16'h0000, 32'h1));
    feed_q = '{8'h34, 8'h12};
    pulse_start();
    seen = 0;
    fork
      feed(0);
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (wen && address == 16'h8000) seen = 1;
      end
    join
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_write: program write not seen required wen at 8000"); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, wen, ren, busy, done, error} !== 6'b0) begin
      errors++; $display("FAIL rstmid_flags: got %b required 000000", {byte_ready, wen, ren, busy, done, error});
    end
    checks++;
    if (word_count !== 11'd0 || address !== 16'h0 || wdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_outs: got count=%0d addr=%h wdata=%h required 0 0000 0", word_count, address, wdata);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_ops: %0d bus ops missing required 0", exp_q.size()); exp_q.delete(); end
    delay_cfg = 0;
    test_basic_load();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_verify_fail();
    test_basic_load();
    test_bad_hi();
    test_timeout();
    test_gapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
